// File: rtl/hex_disp_pkg.sv
// Shared types and active-high glyph constants for the multi-digit hex display driver.
package hex_disp_pkg;

  typedef enum logic [1:0] {StIdle, StScan, StDone} disp_state_e;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] BIT_A = 7'(1 << SEG_A);
  localparam logic [6:0] BIT_B = 7'(1 << SEG_B);
  localparam logic [6:0] BIT_C = 7'(1 << SEG_C);
  localparam logic [6:0] BIT_D = 7'(1 << SEG_D);
  localparam logic [6:0] BIT_E = 7'(1 << SEG_E);
  localparam logic [6:0] BIT_F = 7'(1 << SEG_F);
  localparam logic [6:0] BIT_G = 7'(1 << SEG_G);

  localparam logic [6:0] GLYPH_0 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F;
  localparam logic [6:0] GLYPH_1 = BIT_B | BIT_C;
  localparam logic [6:0] GLYPH_2 = BIT_A | BIT_B | BIT_D | BIT_E | BIT_G;
  localparam logic [6:0] GLYPH_3 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_G;
  localparam logic [6:0] GLYPH_4 = BIT_B | BIT_C | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_5 = BIT_A | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_6 = BIT_A | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_7 = BIT_A | BIT_B | BIT_C;
  localparam logic [6:0] GLYPH_8 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_9 = BIT_A | BIT_B | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_A = BIT_A | BIT_B | BIT_C | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_B = BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_C = BIT_A | BIT_D | BIT_E | BIT_F;
  localparam logic [6:0] GLYPH_D = BIT_B | BIT_C | BIT_D | BIT_E | BIT_G;
  localparam logic [6:0] GLYPH_E = BIT_A | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_F = BIT_A | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/hex_display_driver_if.sv
// Load/display bus between a value source (master) and the hex display driver (slave).
interface hex_display_driver_if #(
  parameter int unsigned N_DIGITS = 6
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*N_DIGITS-1:0]   value;
  logic                    blank_lz;
  logic [N_DIGITS-1:0]     blink_mask;
  logic                    done;
  logic [7*N_DIGITS-1:0]   hex;

  modport master (
    output load_valid, value, blank_lz, blink_mask,
    input  load_ready, done, hex
  );

  modport slave (
    input  load_valid, value, blank_lz, blink_mask,
    output load_ready, done, hex
  );
endinterface

// File: rtl/hex_seg_lut.sv
// Nibble to active-high seven-segment glyph; polarity is applied by the parent.
module hex_seg_lut
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    unique case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/hex_display_driver.sv
// Registered N-digit seven-segment driver, one digit decoded per cycle with leading-zero blanking.
// Digit blinking is built only when HEX_DRV_BLINK_EN is defined.
module hex_display_driver
  import hex_disp_pkg::*;
#(
  parameter int unsigned N_DIGITS   = 6,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input logic               clk,
  input logic               resetn,
  hex_display_driver_if.slave bus
);

  localparam int unsigned    IdxW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DIGITS - 1);
  localparam logic [6:0]     BlankPat = ACTIVE_LOW ? ~GLYPH_BLANK : GLYPH_BLANK;

  if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_n_digits
    $error("N_DIGITS must be in 1..8");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 2");
  end

  disp_state_e           state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  lz_q, lz_d;
  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [6:0]            seg_q [N_DIGITS];
  logic [6:0]            seg_d [N_DIGITS];

  logic       accept;
  logic [3:0] nib;
  logic [6:0] glyph_raw;
  logic [6:0] glyph_pat;

  assign accept = (state_q == StIdle) && bus.load_valid;
  assign nib    = shadow_q[{idx_q, 2'b00} +: 4];

  hex_seg_lut u_lut (
    .nibble (nib),
    .seg    (glyph_raw)
  );

  assign glyph_pat = ACTIVE_LOW ? ~glyph_raw : glyph_raw;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lz_d     = lz_q;
    shadow_d = shadow_q;
    seg_d    = seg_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shadow_d = bus.value;
          idx_d    = LastIdx;
          lz_d     = bus.blank_lz;
          state_d  = StScan;
        end
      end
      StScan: begin
        // Digit 0 always shows a glyph so an all-zero value still reads "0".
        if (lz_q && (nib == 4'h0) && (idx_q != '0)) begin
          seg_d[idx_q] = BlankPat;
        end else begin
          seg_d[idx_q] = glyph_pat;
          lz_d         = 1'b0;
        end
        if (idx_q == '0) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      lz_q     <= 1'b0;
      shadow_q <= '0;
      for (int i = 0; i < N_DIGITS; i++) begin
        seg_q[i] <= BlankPat;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      lz_q     <= lz_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
    end
  end

  logic                blink_on;
  logic [N_DIGITS-1:0] mask_q;

`ifdef HEX_DRV_BLINK_EN
  localparam int unsigned CntW = $clog2(BLINK_DIV);

  logic [CntW-1:0] cnt_q;
  logic            phase_q;

  // Counter free-runs across loads; only reset restarts the blink cadence.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      if (cnt_q == CntW'(BLINK_DIV - 1)) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        mask_q <= bus.blink_mask;
      end
    end
  end

  assign blink_on = phase_q;
`else
  logic unused_blink_mask;

  assign unused_blink_mask = ^bus.blink_mask;
  assign mask_q            = '0;
  assign blink_on          = 1'b0;
`endif

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_out
    assign bus.hex[7*i +: 7] = (blink_on && mask_q[i]) ? BlankPat : seg_q[i];
  end

  assign bus.load_ready = (state_q == StIdle);
  assign bus.done       = (state_q == StDone);

endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboard bench for hex_display_driver: loads push expected displays, a monitor checks on done.
module tb_hex_display_driver;

  localparam int unsigned N  = 6;
  localparam bit          AL = 1'b1;
  localparam int unsigned BD = 4;
`ifdef HEX_DRV_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [41:0] seg;
    logic [5:0]  mask;
    int          acc;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  hex_display_driver_if #(.N_DIGITS(N)) bus ();

  hex_display_driver #(
    .N_DIGITS   (N),
    .ACTIVE_LOW (AL),
    .BLINK_DIV  (BD)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  bit          prev_done = 1'b0;
  logic [41:0] last_seg;
  logic [5:0]  last_mask;

  function automatic logic [6:0] pol(logic [6:0] p);
    return AL ? ~p : p;
  endfunction

  // Display = glyphs, with every digit above the most significant nonzero one blanked if lz.
  function automatic logic [41:0] model_seg(logic [23:0] v, bit lz);
    logic [41:0] r;
    int top = 0;
    for (int i = 0; i < N; i++) if (v[4*i +: 4] != 4'h0) top = i;
    for (int i = 0; i < N; i++) begin
      if (lz && i > top) r[7*i +: 7] = pol(7'h00);
      else               r[7*i +: 7] = pol(GLYPH[v[4*i +: 4]]);
    end
    return r;
  endfunction

  function automatic logic [41:0] overlay(logic [41:0] s, logic [5:0] m, int c);
    logic [41:0] r = s;
    if (BLINK_EN && ((c / BD) % 2) == 1) begin
      for (int i = 0; i < N; i++) if (m[i]) r[7*i +: 7] = pol(7'h00);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (bus.done) begin
        check("done_single_cycle", 64'(prev_done), 64'(0));
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1, expected no pending load (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("accept_to_done", 64'(cyc - e.acc), 64'(N));
          check("hex_at_done", 64'(bus.hex), 64'(overlay(e.seg, e.mask, cyc)));
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic do_load(input logic [23:0] v, input bit lz, input logic [5:0] m, output int acc);
    int n = 0;
    @(negedge clk);
    bus.value      = v;
    bus.blank_lz   = lz;
    bus.blink_mask = m;
    bus.load_valid = 1'b1;
    while (!bus.load_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.load_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got load_ready=0, expected 1 within 50 cycles");
      bus.load_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    q.push_back('{seg: model_seg(v, lz), mask: m, acc: acc});
    last_seg  = model_seg(v, lz);
    last_mask = m;
    @(posedge clk);
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.load_ready && q.size() == 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(bus.load_ready && q.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got ready=%0b pending=%0d, expected ready=1 pending=0",
               bus.load_ready, q.size());
    end
  endtask

  task automatic steady(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("steady_hex", 64'(bus.hex), 64'(overlay(last_seg, last_mask, cyc)));
    end
  endtask

  task automatic check_reset(input string tag);
    logic [41:0] blank_all;
    for (int i = 0; i < N; i++) blank_all[7*i +: 7] = pol(7'h00);
    check({tag, "_hex"}, 64'(bus.hex), 64'(blank_all));
    check({tag, "_ready"}, 64'(bus.load_ready), 64'(1));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    last_seg  = blank_all;
    last_mask = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int          a1, a2;
    logic [41:0] k;
    logic [23:0] v;
    bus.load_valid = 1'b0;
    bus.value      = '0;
    bus.blank_lz   = 1'b0;
    bus.blink_mask = '0;
    #1 resetn = 1'b0;
    #1 check_reset("reset");
    #20;
    @(negedge clk) resetn = 1'b1;

    do_load(24'h0012AF, 1'b0, 6'b0, a1);
    wait_idle();
    k = {7'h40, 7'h40, 7'h79, 7'h24, 7'h08, 7'h0E};
    check("basic_digits", 64'(bus.hex), 64'(k));

    do_load(24'h0012AF, 1'b1, 6'b0, a1);
    wait_idle();
    k = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08, 7'h0E};
    check("lz_nonzero_digits", 64'(bus.hex), 64'(k));

    do_load(24'h000000, 1'b1, 6'b0, a1);
    wait_idle();
    k = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    check("lz_zero_digits", 64'(bus.hex), 64'(k));

    // Busy pulse must be dropped; a held valid lands exactly N+2 edges after the first accept.
    do_load(24'h5A5A5A, 1'b0, 6'b0, a1);
    bus.value      = 24'hFFFFFF;
    bus.load_valid = 1'b1;
    @(negedge clk) bus.load_valid = 1'b0;
    do_load(24'h0C0DE0, 1'b1, 6'b0, a2);
    check("busy_accept_gap", 64'(a2 - a1), 64'(N + 2));
    wait_idle();
    steady(2);

    do_load(24'h0012AF, 1'b0, 6'b000001, a1);
    wait_idle();
    steady(20);

    for (int i = 0; i < 30; i++) begin
      v = 24'($urandom() >> $urandom_range(0, 24));
      do_load(v, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), a1);
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        steady(int'($urandom_range(1, 6)));
      end
    end
    wait_idle();

    do_load(24'h123456, 1'b0, 6'b0, a1);
    @(negedge clk) resetn = 1'b0;
    q.delete();
    #1 check_reset("midscan_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold_done", 64'(bus.done), 64'(0));
    end
    @(negedge clk) resetn = 1'b1;
    steady(12);

    do_load(24'h00BEEF, 1'b1, 6'b100001, a1);
    wait_idle();
    steady(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
